pe_conv_window_gen: RTL and testbench

- Streaming sliding-window generator directly upstream of the conv MAC input buffer.
- Accepts one raster-order pixel (all input channels) per enabled cycle and keeps pKERNEL_SIZE-1 line buffers plus a KxK shift window.
- Emits a full receptive field whenever a complete, stride-aligned KxK window is present.
- Its data_out/valid drive the MAC buffer's data_in/en directly.

---
 rtl/pe_conv_window_gen.sv | 194 +++++++++++++++++++
 tb/tb_pe_conv_window_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_conv_window_gen.sv
// pe_conv_window_gen
//
// Streaming sliding-window generator that feeds the conv MAC input buffer.
// It accepts one raster-order pixel per enabled cycle and keeps K-1 line
// buffers plus a KxK shift window. Whenever a complete, stride-aligned window
// is present, it emits the whole receptive field one cycle after the accepting
// cycle.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   en        data_in carries a valid pixel this cycle
//   data_in   one pixel, all channels packed, channel 0 in the LSBs
//   data_out  packed KxK window; element idx = r*K + c, and idx 0 sits in the MSBs
//   valid     single-cycle pulse marking a new window on data_out
//   last      (only with PE_CONV_WINDOW_LAST_EN) set together with valid for the
//             final window of each frame
//
// Optional feature macro: PE_CONV_WINDOW_LAST_EN adds the 'last' output.
module pe_conv_window_gen #(
  parameter int unsigned pDATA_WIDTH    = 8,
  parameter int unsigned pKERNEL_SIZE   = 3,
  parameter int unsigned pINPUT_CHANNEL = 1,
  parameter int unsigned pINPUT_WIDTH   = 28,
  parameter int unsigned pINPUT_HEIGHT  = 28,
  parameter int unsigned pSTRIDE        = 1
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          en,
  input  logic [pDATA_WIDTH*pINPUT_CHANNEL-1:0]                         data_in,
  output logic [pDATA_WIDTH*pINPUT_CHANNEL*pKERNEL_SIZE*pKERNEL_SIZE-1:0] data_out,
  output logic                                                          valid
`ifdef PE_CONV_WINDOW_LAST_EN
  ,
  output logic                                                          last
`endif
);

  localparam int unsigned K  = pKERNEL_SIZE;
  localparam int unsigned KK = K * K;
  localparam int unsigned PW = pDATA_WIDTH * pINPUT_CHANNEL;
  localparam int unsigned CW = (pINPUT_WIDTH > 1) ? $clog2(pINPUT_WIDTH) : 1;
  localparam int unsigned RW = (pINPUT_HEIGHT > 1) ? $clog2(pINPUT_HEIGHT) : 1;
  localparam int unsigned SW = (pSTRIDE > 1) ? $clog2(pSTRIDE) : 1;

  // Position counters and stride phases
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] col_phase_q, col_phase_d;
  logic [SW-1:0] row_phase_q, row_phase_d;

  logic col_wrap, row_wrap;
  logic col_ok, row_ok;
  logic emit;

  // Datapath storage. It has no reset because the row/col gates keep stale
  // contents from ever reaching data_out.
  logic [PW-1:0] line_buf_q [0:K-2][0:pINPUT_WIDTH-1];
  logic [PW-1:0] win_q      [0:K-1][0:K-1];
  logic [PW-1:0] win_d      [0:K-1][0:K-1];
  logic [PW-1:0] new_col    [0:K-1];

  logic [KK*PW-1:0] packed_d;
  logic [KK*PW-1:0] data_out_q;
  logic             valid_q;

  assign col_wrap = (col_q == CW'(pINPUT_WIDTH - 1));
  assign row_wrap = (row_q == RW'(pINPUT_HEIGHT - 1));
  assign col_ok   = (col_q >= CW'(K - 1));
  assign row_ok   = (row_q >= RW'(K - 1));

  // A window is aligned when both phases are zero. Each phase holds
  // (pos-(K-1)) mod pSTRIDE once the position has reached K-1.
  assign emit = en && row_ok && col_ok && (row_phase_q == '0) && (col_phase_q == '0);

  // Build the incoming right column, top (oldest row) to bottom (data_in).
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = line_buf_q[K-2-r][col_q];
    end
    new_col[K-1] = data_in;
  end

  // Shift the window left by one column and append the new column.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = new_col[r];
    end
  end

  // Pack the window with idx 0 in the MSBs.
  always_comb begin
    packed_d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        packed_d[(KK-(r*K+c))*PW-1 -: PW] = win_d[r][c];
      end
    end
  end

  // Counter and phase next-state.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    col_phase_d = col_phase_q;
    row_phase_d = row_phase_q;

    if (col_wrap) begin
      col_d       = '0;
      col_phase_d = '0;
    end else begin
      col_d = col_q + CW'(1);
      if (col_ok) begin
        col_phase_d = (col_phase_q == SW'(pSTRIDE - 1)) ? '0 : col_phase_q + SW'(1);
      end else begin
        col_phase_d = '0;
      end
    end

    if (col_wrap) begin
      if (row_wrap) begin
        row_d       = '0;
        row_phase_d = '0;
      end else begin
        row_d = row_q + RW'(1);
        if (row_ok) begin
          row_phase_d = (row_phase_q == SW'(pSTRIDE - 1)) ? '0 : row_phase_q + SW'(1);
        end else begin
          row_phase_d = '0;
        end
      end
    end
  end

`ifdef PE_CONV_WINDOW_LAST_EN
  // Bottom-right position of the last stride-aligned window in a frame.
  localparam int unsigned LastCol = (K - 1) + ((pINPUT_WIDTH - K) / pSTRIDE) * pSTRIDE;
  localparam int unsigned LastRow = (K - 1) + ((pINPUT_HEIGHT - K) / pSTRIDE) * pSTRIDE;

  logic last_q, last_d;

  assign last_d = emit && (row_q == RW'(LastRow)) && (col_q == CW'(LastCol));
  assign last   = last_q;
`endif

  // Control state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      col_phase_q <= '0;
      row_phase_q <= '0;
      valid_q     <= 1'b0;
      data_out_q  <= '0;
`ifdef PE_CONV_WINDOW_LAST_EN
      last_q      <= 1'b0;
`endif
    end else begin
      valid_q <= emit;
`ifdef PE_CONV_WINDOW_LAST_EN
      last_q  <= last_d;
`endif
      if (en) begin
        col_q       <= col_d;
        row_q       <= row_d;
        col_phase_q <= col_phase_d;
        row_phase_q <= row_phase_d;
      end
      if (emit) begin
        data_out_q <= packed_d;
      end
    end
  end

  // Line buffers and window. Each column slot of a line buffer pushes down
  // one row when a new pixel for that column arrives.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      win_q                <= win_d;
      line_buf_q[0][col_q] <= data_in;
      for (int i = 1; i < K - 1; i++) begin
        line_buf_q[i][col_q] <= line_buf_q[i-1][col_q];
      end
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_pe_conv_window_gen.sv
// Testbench for pe_conv_window_gen. It drives three instances with the same
// stimulus: the basic 5x5 K=3 case, a stride-2 variant and a two-channel
// variant. A positional reference model derives the expected windows directly
// from stored image pixels.
module tb_pe_conv_window_gen;

  localparam int W = 5;
  localparam int H = 5;
  localparam int K = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [7:0]   din8;
  logic [15:0]  din16;
  logic [71:0]  dout_a, dout_s;
  logic [143:0] dout_c;
  logic         valid_a, valid_s, valid_c;
`ifdef PE_CONV_WINDOW_LAST_EN
  logic         last_a, last_s, last_c;
`endif

  always #5 clk = ~clk;

  pe_conv_window_gen #(
    .pDATA_WIDTH(8), .pKERNEL_SIZE(K), .pINPUT_CHANNEL(1),
    .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H), .pSTRIDE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .data_in(din8), .data_out(dout_a), .valid(valid_a)
`ifdef PE_CONV_WINDOW_LAST_EN
    , .last(last_a)
`endif
  );

  pe_conv_window_gen #(
    .pDATA_WIDTH(8), .pKERNEL_SIZE(K), .pINPUT_CHANNEL(1),
    .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H), .pSTRIDE(2)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .data_in(din8), .data_out(dout_s), .valid(valid_s)
`ifdef PE_CONV_WINDOW_LAST_EN
    , .last(last_s)
`endif
  );

  pe_conv_window_gen #(
    .pDATA_WIDTH(8), .pKERNEL_SIZE(K), .pINPUT_CHANNEL(2),
    .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H), .pSTRIDE(1)
  ) dut_c (
    .clk(clk), .rst(rst), .en(en), .data_in(din16), .data_out(dout_c), .valid(valid_c)
`ifdef PE_CONV_WINDOW_LAST_EN
    , .last(last_c)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int           pix [H][W];
  int           mr, mc;
  logic         ev_a, ev_s, el_a, el_s;
  logic [71:0]  ed_a, ed_s;
  logic [143:0] ed_c;
  int           cnt_a, cnt_s;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle, advance the model, then compare every output.
  task automatic step(input bit e, input int v, input bit r);
    int          w, p, q;
    bit          emit1, emit2;
    logic [71:0]  wa;
    logic [143:0] wc;
    w     = v + 50;
    en    = e;
    rst   = r;
    din8  = v[7:0];
    din16 = {w[7:0], v[7:0]};
    @(posedge clk);
    #1;
    el_a = 1'b0;
    el_s = 1'b0;
    if (r) begin
      mr = 0; mc = 0;
      ev_a = 1'b0; ev_s = 1'b0;
      ed_a = '0; ed_s = '0; ed_c = '0;
    end else if (e) begin
      pix[mr][mc] = v;
      emit1 = (mr >= K - 1) && (mc >= K - 1);
      emit2 = emit1 && ((mr - (K - 1)) % 2 == 0) && ((mc - (K - 1)) % 2 == 0);
      wa = '0;
      wc = '0;
      if (emit1) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            p  = pix[mr-K+1+i][mc-K+1+j];
            q  = p + 50;
            wa = {wa[63:0], p[7:0]};
            wc = {wc[127:0], q[7:0], p[7:0]};
          end
        end
      end
      ev_a = emit1;
      ev_s = emit2;
      if (emit1) begin
        ed_a = wa;
        ed_c = wc;
        el_a = (mr + 1 > H - 1) && (mc + 1 > W - 1);
      end
      if (emit2) begin
        ed_s = wa;
        el_s = (mr + 2 > H - 1) && (mc + 2 > W - 1);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end else begin
      ev_a = 1'b0;
      ev_s = 1'b0;
    end
    cnt_a += int'(valid_a);
    cnt_s += int'(valid_s);
    chk("valid_a", 144'(valid_a), 144'(ev_a));
    chk("valid_s", 144'(valid_s), 144'(ev_s));
    chk("valid_c", 144'(valid_c), 144'(ev_a));
    chk("data_a", 144'(dout_a), 144'(ed_a));
    chk("data_s", 144'(dout_s), 144'(ed_s));
    chk("data_c", dout_c, ed_c);
`ifdef PE_CONV_WINDOW_LAST_EN
    chk("last_a", 144'(last_a), 144'(el_a));
    chk("last_s", 144'(last_s), 144'(el_s));
    chk("last_c", 144'(last_c), 144'(el_a));
`endif
  endtask

  // Feed pixels [first, last_i) of a frame, with optional random bubbles.
  task automatic frame(input int base, input bit rnd, input int gap,
                       input int first, input int last_i);
    int v;
    if (first == 0) begin
      cnt_a = 0;
      cnt_s = 0;
    end
    for (int n = first; n < last_i; n++) begin
      v = rnd ? int'($urandom_range(0, 200)) : base + n;
      repeat ($urandom_range(0, gap)) step(1'b0, int'($urandom_range(0, 255)), 1'b0);
      step(1'b1, v, 1'b0);
    end
    if (last_i == W * H) begin
      chk("count_a", 144'(cnt_a), 144'(9));
      chk("count_s", 144'(cnt_s), 144'(4));
    end
  endtask

  initial begin
    en = 1'b0; rst = 1'b1; din8 = '0; din16 = '0;
    mr = 0; mc = 0; ev_a = 1'b0; ev_s = 1'b0; el_a = 1'b0; el_s = 1'b0;
    ed_a = '0; ed_s = '0; ed_c = '0; cnt_a = 0; cnt_s = 0;

    // Reset, with en held high during the second reset cycle
    step(1'b0, 0, 1'b1);
    step(1'b1, 7, 1'b1);

    // Basic frame
    frame(0, 1'b0, 0, 0, 13);
    chk("first_win_a", 144'(dout_a), 144'(72'h000102050607_0a0b0c));
    chk("first_c_hi", 144'(dout_c[143:128]), 144'(16'h3200));
    chk("first_c_lo", 144'(dout_c[15:0]), 144'(16'h3e0c));
    frame(0, 1'b0, 0, 13, 25);
    chk("last_win_a", 144'(dout_a), 144'(72'h0c0d0e111213161718));

    // Back-to-back second frame
    frame(100, 1'b0, 0, 0, 12);
    chk("f2_early_cnt", 144'(cnt_a), 144'(0));
    frame(100, 1'b0, 0, 12, 13);
    chk("f2_first_win", 144'(dout_a), 144'(72'h646566696a6b6e6f70));
    frame(100, 1'b0, 0, 13, 25);

    // Random bubbles
    frame(0, 1'b0, 3, 0, 25);

    // Reset mid-frame after pixel 17, then a fresh frame
    frame(0, 1'b0, 0, 0, 18);
    step(1'b1, 99, 1'b1);
    frame(0, 1'b0, 0, 0, 25);

    // Random pixel values with bubbles
    repeat (3) frame(0, 1'b1, 3, 0, 25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
